// File: rtl/fifo_read_engine.sv
// Read-side controller for the 8-deep FIFO: burst/flush-triggered drains,
// one read in flight, 2-entry output buffer on a valid/ready stream, read error counter.
module fifo_read_engine #(
    parameter int DATA_W = 32,
    parameter int THRESH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [3:0]        data_count,
    input  logic              rd_ack,
    input  logic              rd_err,
    input  logic [DATA_W-1:0] dout,
    output logic              rd_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam logic       STATE_IDLE  = 1'b0;
    localparam logic       STATE_DRAIN = 1'b1;
    localparam logic [3:0] THRESH_L    = 4'(THRESH);

    logic              state_q, state_d, state_n_s;
    logic              pend_q, pend_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              push_s, pop_s, rd_en_s, trigger_s;
    logic [3:0]        avail_s;
    logic [1:0]        occ_pop_s, slots_s;

    // Read issue: an ack only counts while a read is pending, so a late ack after reset is dropped.
    always_comb begin
        push_s    = rd_ack & pend_q;
        pop_s     = (occ_q != 2'd0) & out_ready;
        avail_s   = data_count - {3'b000, pend_q};
        occ_pop_s = occ_q - {1'b0, pop_s};
        slots_s   = occ_pop_s + {1'b0, pend_q};
        // One read in flight at a time; the slot check keeps the 2-entry buffer from overflowing.
        rd_en_s   = (state_q == STATE_DRAIN) & (avail_s != 4'd0) & ~pend_q & (slots_s < 2'd2);
    end

    // Drain state machine; a read error always drops back to IDLE.
    always_comb begin
        trigger_s = (data_count >= THRESH_L) | flush;
        state_n_s = state_q;
        case (state_q)
            STATE_IDLE: begin
                if (trigger_s) begin
                    state_n_s = STATE_DRAIN;
                end else begin
                    state_n_s = STATE_IDLE;
                end
            end
            STATE_DRAIN: begin
                if ((avail_s == 4'd0) && !pend_q && !flush) begin
                    state_n_s = STATE_IDLE;
                end else begin
                    state_n_s = STATE_DRAIN;
                end
            end
            default: state_n_s = STATE_IDLE;
        endcase
        if (rd_err) begin
            state_d = STATE_IDLE;
        end else begin
            state_d = state_n_s;
        end
    end

    // Pending-read flag and saturating error counter.
    always_comb begin
        if (rd_en_s) begin
            pend_d = 1'b1;
        end else if (rd_ack || rd_err) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (rd_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Two-entry output buffer; head drives out_data and only moves on pop or fill-from-empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_pop_s + {1'b0, push_s};
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = dout;
                end else begin
                    tail_d = dout;
                end
            end
            2'b01: head_d = tail_q;
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = dout;
                end else begin
                    head_d = tail_q;
                    tail_d = dout;
                end
            end
            default: begin
                head_d = head_q;
                tail_d = tail_q;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= STATE_IDLE;
            pend_q    <= 1'b0;
            occ_q     <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            occ_q     <= occ_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_en     = rd_en_s;
    assign out_data  = head_q;
    assign out_valid = (occ_q != 2'd0);
    assign busy      = (state_q == STATE_DRAIN);
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fifo_read_engine.sv
// Directed bench for fifo_read_engine with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_read_engine;

    localparam int DATA_W = 32;
    localparam int THRESH = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [3:0]        data_count;
    logic              rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [7:0]        err_cnt;

    // FIFO model state
    logic              fifo_ack = 1'b0;
    logic              fifo_err = 1'b0;
    logic [DATA_W-1:0] fifo_dout = '0;
    int                fifo_cnt = 0;
    logic [DATA_W-1:0] fifo_mem[$];
    int                rd_cnt = 0;
    logic              m_clr = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    int                err_at = 0;
    bit                err_all = 1'b0;

    // Bench bookkeeping
    int                n_checks = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] captured[$];
    bit                toggle_mode = 1'b0;
    logic              ready_fixed = 1'b1;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    int                stall_err = 0;
    int                rd_hi = 0;
    bit                saw_busy = 1'b0;

    typedef struct {
        int n_words;
        bit use_flush;
        bit toggle;
        int err_at;
        int exp_words;
        int exp_reads;
        int exp_err;
    } vec_t;

    vec_t vecs[7];

    assign data_count = fifo_cnt[3:0];

    always #5 clk = ~clk;

    fifo_read_engine #(.DATA_W(DATA_W), .THRESH(THRESH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .data_count (data_count),
        .rd_ack     (fifo_ack),
        .rd_err     (fifo_err),
        .dout       (fifo_dout),
        .rd_en      (rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    // FIFO: rd_en at edge N gives ack/err in cycle N+1; count drops at the end of the ack cycle.
    always @(posedge clk) begin
        if (m_clr) begin
            fifo_mem.delete();
            fifo_cnt <= 0;
            fifo_ack <= 1'b0;
            fifo_err <= 1'b0;
            rd_cnt   <= 0;
        end else begin
            if (fifo_ack) void'(fifo_mem.pop_front());
            fifo_ack <= 1'b0;
            fifo_err <= 1'b0;
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1;
                if (err_all || (err_at == rd_cnt + 1) || (fifo_mem.size() == 0)) begin
                    fifo_err <= 1'b1;
                end else begin
                    fifo_ack  <= 1'b1;
                    fifo_dout <= fifo_mem[0];
                end
            end
            if (wr_en) fifo_mem.push_back(wr_data);
            fifo_cnt <= fifo_cnt + (wr_en ? 1 : 0) - (fifo_ack ? 1 : 0);
        end
    end

    function automatic logic [DATA_W-1:0] word_of(input int v, input int i);
        return 32'hC0DE0000 + 32'(v * 256 + i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_clr = 1'b1;
        wr_en = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_clr = 1'b0;
        captured.delete();
        prev_stall = 1'b0;
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit later.
    task automatic tick(input logic wr, input logic [DATA_W-1:0] wd, input logic fl);
        @(negedge clk);
        wr_en   = wr;
        wr_data = wd;
        flush   = fl;
        if (toggle_mode) out_ready = ~out_ready;
        else             out_ready = ready_fixed;
        #1;
        if (prev_stall && !(out_valid && (out_data == prev_data))) stall_err++;
        if (out_valid && out_ready) captured.push_back(out_data);
        if (rd_en) rd_hi++;
        if (busy) saw_busy = 1'b1;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    initial begin
        vecs[0] = '{4, 1'b0, 1'b0, 0, 4, 4, 0};
        vecs[1] = '{2, 1'b1, 1'b0, 0, 2, 2, 0};
        vecs[2] = '{8, 1'b0, 1'b1, 0, 8, 8, 0};
        vecs[3] = '{4, 1'b0, 1'b0, 3, 2, 3, 1};
        vecs[4] = '{3, 1'b0, 1'b0, 0, 0, 0, 0};
        vecs[5] = '{3, 1'b1, 1'b1, 0, 3, 3, 0};
        vecs[6] = '{1, 1'b1, 1'b0, 0, 1, 1, 0};

        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_clr = 1'b0;
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Table-driven drains
        for (int v = 0; v < 7; v++) begin
            do_reset();
            toggle_mode = vecs[v].toggle;
            ready_fixed = 1'b1;
            out_ready   = 1'b0;
            err_at      = vecs[v].err_at;
            stall_err   = 0;
            saw_busy    = 1'b0;
            for (int i = 0; i < vecs[v].n_words; i++) tick(1'b1, word_of(v, i), 1'b0);
            if (vecs[v].n_words < THRESH) begin
                rd_hi = 0;
                repeat (20) tick(1'b0, '0, 1'b0);
                check("idle_rd_en_cycles", rd_hi, 0);
            end
            if (vecs[v].use_flush) tick(1'b0, '0, 1'b1);
            repeat (80) tick(1'b0, '0, 1'b0);
            check("n_words", captured.size(), vecs[v].exp_words);
            for (int i = 0; i < vecs[v].exp_words; i++)
                check("word", (i < captured.size()) ? captured[i] : 32'hDEADDEAD, word_of(v, i));
            check("rd_pulses", rd_cnt, vecs[v].exp_reads);
            check("err_cnt", err_cnt, vecs[v].exp_err);
            check("busy_seen", saw_busy, (vecs[v].exp_reads > 0) ? 1 : 0);
            check("busy_end", busy, 0);
            check("stall_hold", stall_err, 0);
            err_at = 0;
        end

        // Backpressure: only two reads fit while the sink is stalled
        do_reset();
        toggle_mode = 1'b0;
        ready_fixed = 1'b0;
        stall_err   = 0;
        for (int i = 0; i < 8; i++) tick(1'b1, word_of(10, i), 1'b0);
        repeat (20) tick(1'b0, '0, 1'b0);
        check("bp_reads", rd_cnt, 2);
        check("bp_data_count", data_count, 6);
        check("bp_rd_en", rd_en, 0);
        check("bp_out_valid", out_valid, 1);
        ready_fixed = 1'b1;
        repeat (80) tick(1'b0, '0, 1'b0);
        check("bp_n_words", captured.size(), 8);
        for (int i = 0; i < 8; i++)
            check("bp_word", (i < captured.size()) ? captured[i] : 32'hDEADDEAD, word_of(10, i));
        check("bp_stall_hold", stall_err, 0);

        // Reset while a word is buffered and a read is being issued
        do_reset();
        ready_fixed = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick((i < 8) ? 1'b1 : 1'b0, word_of(11, i), 1'b0);
                if (out_valid && rd_en) found = 1'b1;
            end
            check("mid_reset_setup_found", found, 1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            wr_en = 1'b0;
            prev_stall = 1'b0;
            #1;
            check("mr_out_valid", out_valid, 0);
            check("mr_rd_en", rd_en, 0);
            check("mr_busy", busy, 0);
            check("mr_err_cnt", err_cnt, 0);
            @(negedge clk);
            #1;
            check("mr_late_ack_dropped", out_valid, 0);
            check("mr_out_data", out_data, 0);
        end

        // Error counter saturation
        do_reset();
        ready_fixed = 1'b1;
        err_all = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, word_of(12, i), 1'b0);
        repeat (1100) tick(1'b0, '0, 1'b0);
        check("err_reads_ge_300", (rd_cnt >= 300) ? 1 : 0, 1);
        check("err_saturated", err_cnt, 8'hFF);
        err_all = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
